pipeline_hazard_unit: RTL and testbench
=======================================

Name: pipeline_hazard_unit

Overview:
Stall and flush controller for the 5-stage pipeline. It consumes the decode stage's source-usage outputs (Rs1/Rs2 used and addresses), destination address and RegWrite. It keeps a 3-deep scoreboard of in-flight destinations in the EX, MEM and WB stages. Without forwarding, it generates PC/IF-ID stall, ID-EX bubble and branch-redirect flush controls, and counts stall cycles.

Parameters:
WB_BYPASS, 1, 1 = the regfile writes in the first half-cycle, so a WB-stage match is not a hazard; 0 = a WB match stalls
CNT_W, 32, width of the stall/flush performance counters

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous reset, active-high
valid_ID  in  1  ID holds a real instruction (not a bubble)
Rs1_used  in  1  ID instruction reads rs1
Rs2_used  in  1  ID instruction reads rs2
Rs1_addr_ID  in  5  rs1 index in ID
Rs2_addr_ID  in  5  rs2 index in ID
Rd_addr_ID  in  5  rd index in ID
RegWrite_ID  in  1  ID instruction writes rd
Branch_taken_EX  in  1  taken branch/jump resolved in EX; redirect this cycle
stall_PC  out  1  hold PC
stall_IFID  out  1  hold IF/ID register
flush_IFID  out  1  clear IF/ID to NOP
flush_IDEX  out  1  load bubble into ID/EX
stall_cnt  out  CNT_W  cycles with a data-hazard stall
flush_cnt  out  CNT_W  redirects taken

Behaviour:
- Scoreboard: three registered entries sb_EX, sb_MEM, sb_WB, each {v, rd[4:0]}.
  - Every cycle: sb_WB<=sb_MEM, sb_MEM<=sb_EX, sb_EX<=new.
  - Downstream stages never stall.
- new entry:
  - {1, Rd_addr_ID} if valid_ID & RegWrite_ID & Rd_addr_ID!=0 & !hazard & !Branch_taken_EX.
  - Otherwise {0, x}. rd compares are ignored when v=0.
- match(s, a) = s.v & s.rd==a & a!=0. x0 is never a hazard.
- hazard = valid_ID & ((Rs1_used & (match(sb_EX,Rs1) | match(sb_MEM,Rs1) | (!WB_BYPASS & match(sb_WB,Rs1)))) | same for Rs2).
  - Purely combinational from current inputs plus the scoreboard registers. Zero-cycle latency.
- Priority: Branch_taken_EX over hazard.
  - Branch_taken_EX=1: flush_IFID=1, flush_IDEX=1, stall_PC=0, stall_IFID=0. The ID instruction is killed; no stall is counted.
  - else hazard=1: stall_PC=1, stall_IFID=1, flush_IDEX=1, flush_IFID=0.
  - else: all four controls 0.
- Stall duration:
  - Producer directly ahead in EX: 2 stall cycles (producer moves to MEM, then WB).
  - Producer in MEM: 1 stall cycle.
  - WB_BYPASS=0 adds 1 cycle in each case.
- Counters:
  - stall_cnt += 1 on each cycle with the hazard branch taken (branch not asserted).
  - flush_cnt += 1 on each Branch_taken_EX cycle.
  - Both wrap modulo 2^CNT_W.
- Reset (sync, rst=1 at posedge): all scoreboard v<=0, counters<=0.
  - Controls are combinational, so they are 0 whenever rst is asserted; this is forced regardless of inputs.
  - A stall in progress is abandoned; the next cycle evaluates against an empty scoreboard.
- Reset mid-stall: the post-reset ID instruction proceeds with no stall.
- Simultaneous rs1 and rs2 matches against different stages: the stall lasts until both clear, i.e. the max of the two durations.
- valid_ID=0: never hazards, inserts a bubble entry.

Test Plan:
- Reset, then sequence addi x5 (RegWrite, rd=5) followed by add reading rs1=x5 → stall_PC/stall_IFID/flush_IDEX high exactly 2 cycles, stall_cnt=2.
- Producer rd=5, one independent instruction, then consumer rs2=x5 → 1 stall cycle. With WB_BYPASS=0 → 2 stall cycles.
- Producer rd=0, then consumer rs1=x0 used → no stall, stall_cnt=0. Producer RegWrite_ID=0 rd=7, consumer rs1=x7 → no stall.
- Hazard pending and Branch_taken_EX=1 same cycle → flush_IFID=1, flush_IDEX=1, stall_PC=0; flush_cnt=1, stall_cnt unchanged. Next cycle, a consumer of the killed instruction's rd does not stall.
- rs1 matches sb_MEM (rd=3) and rs2 matches sb_EX (rd=4) → 2 stall cycles total.
- Assert rst during the first stall cycle → controls 0 that cycle; after release the same consumer proceeds without stall and counters read 0.
- Preload stall_cnt to 2^CNT_W-1 (CNT_W=4 build: 15), cause 1 stall → stall_cnt=0.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// Interlocking hazard controller for a 5-stage pipeline without forwarding: tracks the
// destinations in flight in EX/MEM/WB, stalls dependent ID instructions, flushes on redirect.
module pipeline_hazard_unit #(
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_ID,
    input  logic             Rs1_used,
    input  logic             Rs2_used,
    input  logic [4:0]       Rs1_addr_ID,
    input  logic [4:0]       Rs2_addr_ID,
    input  logic [4:0]       Rd_addr_ID,
    input  logic             RegWrite_ID,
    input  logic             Branch_taken_EX,
    output logic             stall_PC,
    output logic             stall_IFID,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{v: 1'b0, rd: 5'd0};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    sb_entry_t        sb_ex_r;
    sb_entry_t        sb_mem_r;
    sb_entry_t        sb_wb_r;
    sb_entry_t        sb_new_s;
    logic             rs1_hit_s;
    logic             rs2_hit_s;
    logic             hazard_s;
    logic             issue_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // x0 is hardwired to zero, so it can never carry a dependency
    function automatic logic sb_match(input sb_entry_t e, input logic [4:0] a);
        return e.v & (e.rd == a) & (a != 5'd0);
    endfunction

    function automatic logic src_hit(input sb_entry_t ex, input sb_entry_t mem,
                                     input sb_entry_t wb, input logic [4:0] a);
        logic wb_hit;
        wb_hit = (WB_BYPASS == 1'b0) ? sb_match(wb, a) : 1'b0;
        return sb_match(ex, a) | sb_match(mem, a) | wb_hit;
    endfunction

    // Source operands of the ID instruction against the in-flight destinations
    always_comb begin
        rs1_hit_s = Rs1_used & src_hit(sb_ex_r, sb_mem_r, sb_wb_r, Rs1_addr_ID);
        rs2_hit_s = Rs2_used & src_hit(sb_ex_r, sb_mem_r, sb_wb_r, Rs2_addr_ID);
        hazard_s  = valid_ID & (rs1_hit_s | rs2_hit_s);
    end

    // Destination entering EX: only an instruction that actually leaves ID this cycle
    always_comb begin
        issue_s  = valid_ID & RegWrite_ID & (Rd_addr_ID != 5'd0) & ~hazard_s & ~Branch_taken_EX;
        sb_new_s = SB_EMPTY;
        if (issue_s) begin
            sb_new_s.v  = 1'b1;
            sb_new_s.rd = Rd_addr_ID;
        end else begin
            sb_new_s = SB_EMPTY;
        end
    end

    // Pipeline controls; redirect wins over a data hazard, reset forces everything low
    always_comb begin
        stall_PC   = 1'b0;
        stall_IFID = 1'b0;
        flush_IFID = 1'b0;
        flush_IDEX = 1'b0;
        if (rst) begin
            stall_PC   = 1'b0;
            stall_IFID = 1'b0;
            flush_IFID = 1'b0;
            flush_IDEX = 1'b0;
        end else if (Branch_taken_EX) begin
            stall_PC   = 1'b0;
            stall_IFID = 1'b0;
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
        end else if (hazard_s) begin
            stall_PC   = 1'b1;
            stall_IFID = 1'b1;
            flush_IFID = 1'b0;
            flush_IDEX = 1'b1;
        end else begin
            stall_PC   = 1'b0;
            stall_IFID = 1'b0;
            flush_IFID = 1'b0;
            flush_IDEX = 1'b0;
        end
    end

    // Scoreboard shift; downstream stages never stall so it advances every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_ex_r  <= SB_EMPTY;
            sb_mem_r <= SB_EMPTY;
            sb_wb_r  <= SB_EMPTY;
        end else begin
            sb_ex_r  <= sb_new_s;
            sb_mem_r <= sb_ex_r;
            sb_wb_r  <= sb_mem_r;
        end
    end

    // Performance counters; a killed instruction's hazard is not counted as a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (Branch_taken_EX) begin
            stall_cnt_r <= stall_cnt_r;
            flush_cnt_r <= flush_cnt_r + CNT_ONE;
        end else if (hazard_s) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
            flush_cnt_r <= flush_cnt_r;
        end else begin
            stall_cnt_r <= stall_cnt_r;
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit: three builds (bypass, no bypass, 4-bit counters)
// checked against hand-derived vectors and a producer-age reference model.
module tb_pipeline_hazard_unit;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic       r1u;
        logic       r2u;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       br;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [3:0] ctl;
        logic [7:0] scnt;
        logic [7:0] fcnt;
    } vec_t;

    localparam in_t IDLE = '0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t din0 = IDLE;
    in_t din1 = IDLE;
    in_t din2 = IDLE;
    wire [3:0]  ctl0, ctl1, ctl2;
    wire [31:0] scnt0, fcnt0, scnt1, fcnt1;
    wire [3:0]  scnt2, fcnt2;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // reference model: cycle at which each register was last issued into EX
    int          last_issue [3][32];
    logic [31:0] m_stall [3];
    logic [31:0] m_flush [3];

    pipeline_hazard_unit #(.WB_BYPASS(1'b1), .CNT_W(32)) u_dut0 (
        .clk(clk), .rst(din0.rst), .valid_ID(din0.valid), .Rs1_used(din0.r1u),
        .Rs2_used(din0.r2u), .Rs1_addr_ID(din0.rs1), .Rs2_addr_ID(din0.rs2),
        .Rd_addr_ID(din0.rd), .RegWrite_ID(din0.rw), .Branch_taken_EX(din0.br),
        .stall_PC(ctl0[3]), .stall_IFID(ctl0[2]), .flush_IFID(ctl0[1]), .flush_IDEX(ctl0[0]),
        .stall_cnt(scnt0), .flush_cnt(fcnt0)
    );

    pipeline_hazard_unit #(.WB_BYPASS(1'b0), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst(din1.rst), .valid_ID(din1.valid), .Rs1_used(din1.r1u),
        .Rs2_used(din1.r2u), .Rs1_addr_ID(din1.rs1), .Rs2_addr_ID(din1.rs2),
        .Rd_addr_ID(din1.rd), .RegWrite_ID(din1.rw), .Branch_taken_EX(din1.br),
        .stall_PC(ctl1[3]), .stall_IFID(ctl1[2]), .flush_IFID(ctl1[1]), .flush_IDEX(ctl1[0]),
        .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    pipeline_hazard_unit #(.WB_BYPASS(1'b1), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(din2.rst), .valid_ID(din2.valid), .Rs1_used(din2.r1u),
        .Rs2_used(din2.r2u), .Rs1_addr_ID(din2.rs1), .Rs2_addr_ID(din2.rs2),
        .Rd_addr_ID(din2.rd), .RegWrite_ID(din2.rw), .Branch_taken_EX(din2.br),
        .stall_PC(ctl2[3]), .stall_IFID(ctl2[2]), .flush_IFID(ctl2[1]), .flush_IDEX(ctl2[0]),
        .stall_cnt(scnt2), .flush_cnt(fcnt2)
    );

    function automatic logic [3:0] get_ctl(input int d);
        case (d)
            0:       return ctl0;
            1:       return ctl1;
            default: return ctl2;
        endcase
    endfunction

    function automatic logic [31:0] get_scnt(input int d);
        case (d)
            0:       return scnt0;
            1:       return scnt1;
            default: return {28'd0, scnt2};
        endcase
    endfunction

    function automatic logic [31:0] get_fcnt(input int d);
        case (d)
            0:       return fcnt0;
            1:       return fcnt1;
            default: return {28'd0, fcnt2};
        endcase
    endfunction

    // a producer blocks readers for 2 cycles after issue, 3 when WB cannot bypass
    function automatic int window(input int d);
        return (d == 1) ? 3 : 2;
    endfunction

    function automatic logic [31:0] cmask(input int d);
        return (d == 2) ? 32'h0000_000F : 32'hFFFF_FFFF;
    endfunction

    function automatic bit recent(input int d, input logic [4:0] a);
        return (a != 5'd0) && ((cyc - last_issue[d][a]) <= window(d));
    endfunction

    function automatic vec_t mk(input logic rst, input logic valid, input logic r1u, input logic r2u,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic rw, input logic br, input logic [3:0] ctl,
                                input logic [7:0] sc, input logic [7:0] fc);
        vec_t v;
        v.in  = '{rst: rst, valid: valid, r1u: r1u, r2u: r2u, rs1: rs1, rs2: rs2,
                  rd: rd, rw: rw, br: br};
        v.ctl  = ctl;
        v.scnt = sc;
        v.fcnt = fc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset(input int d);
        for (int r = 0; r < 32; r++) last_issue[d][r] = -1000;
        m_stall[d] = 32'd0;
        m_flush[d] = 32'd0;
    endtask

    // one pipeline cycle on build d; the other builds see idle inputs
    task automatic step(input int d, input in_t v, input bit chk, input vec_t e, input string tag);
        logic [3:0] m_ctl;
        bit         haz;
        din0 = IDLE;
        din1 = IDLE;
        din2 = IDLE;
        case (d)
            0:       din0 = v;
            1:       din1 = v;
            default: din2 = v;
        endcase
        @(negedge clk);
        haz = !v.rst && v.valid && ((v.r1u && recent(d, v.rs1)) || (v.r2u && recent(d, v.rs2)));
        if (v.rst)       m_ctl = 4'b0000;
        else if (v.br)   m_ctl = 4'b0011;
        else if (haz)    m_ctl = 4'b1101;
        else             m_ctl = 4'b0000;
        check($sformatf("%s d%0d ctl(model)", tag, d), {28'd0, get_ctl(d)}, {28'd0, m_ctl});
        check($sformatf("%s d%0d stall_cnt(model)", tag, d), get_scnt(d), m_stall[d]);
        check($sformatf("%s d%0d flush_cnt(model)", tag, d), get_fcnt(d), m_flush[d]);
        if (chk) begin
            check($sformatf("%s d%0d ctl(vec)", tag, d), {28'd0, get_ctl(d)}, {28'd0, e.ctl});
            check($sformatf("%s d%0d stall_cnt(vec)", tag, d), get_scnt(d), {24'd0, e.scnt});
            check($sformatf("%s d%0d flush_cnt(vec)", tag, d), get_fcnt(d), {24'd0, e.fcnt});
        end
        @(posedge clk);
        if (v.rst) begin
            model_reset(d);
        end else begin
            if (v.br)      m_flush[d] = (m_flush[d] + 32'd1) & cmask(d);
            else if (haz)  m_stall[d] = (m_stall[d] + 32'd1) & cmask(d);
            if (v.valid && v.rw && (v.rd != 5'd0) && !haz && !v.br) last_issue[d][v.rd] = cyc;
        end
        cyc++;
        #1;
    endtask

    vec_t tbl0 [25];
    vec_t tbl1 [10];
    vec_t nov;
    in_t  rv;
    in_t  prod5;
    in_t  cons5;

    initial begin
        nov = '0;
        // x5 producer chain, x0 / RegWrite=0 cases, branch kill, dual-source, reset mid-stall
        tbl0[0]  = mk(1,0,0,0, 0, 0, 0,0,0, 4'b0000, 0, 0);
        tbl0[1]  = mk(0,1,1,0, 0, 0, 5,1,0, 4'b0000, 0, 0);
        tbl0[2]  = mk(0,1,1,1, 5, 6, 7,1,0, 4'b1101, 0, 0);
        tbl0[3]  = mk(0,1,1,1, 5, 6, 7,1,0, 4'b1101, 1, 0);
        tbl0[4]  = mk(0,1,1,1, 5, 6, 7,1,0, 4'b0000, 2, 0);
        tbl0[5]  = mk(0,1,1,0, 0, 0, 5,1,0, 4'b0000, 2, 0);
        tbl0[6]  = mk(0,1,1,0, 0, 0, 9,1,0, 4'b0000, 2, 0);
        tbl0[7]  = mk(0,1,0,1, 9, 5, 0,0,0, 4'b1101, 2, 0);
        tbl0[8]  = mk(0,1,0,1, 9, 5, 0,0,0, 4'b0000, 3, 0);
        tbl0[9]  = mk(0,1,1,0, 0, 0, 0,1,0, 4'b0000, 3, 0);
        tbl0[10] = mk(0,1,1,0, 0, 0, 0,0,0, 4'b0000, 3, 0);
        tbl0[11] = mk(0,1,1,0, 0, 0, 7,0,0, 4'b0000, 3, 0);
        tbl0[12] = mk(0,1,1,0, 7, 0, 0,0,0, 4'b0000, 3, 0);
        tbl0[13] = mk(0,1,1,0, 0, 0, 8,1,0, 4'b0000, 3, 0);
        tbl0[14] = mk(0,1,1,0, 8, 0,10,1,1, 4'b0011, 3, 0);
        tbl0[15] = mk(0,1,1,0,10, 0, 0,0,0, 4'b0000, 3, 1);
        tbl0[16] = mk(0,1,1,0, 0, 0, 3,1,0, 4'b0000, 3, 1);
        tbl0[17] = mk(0,1,1,0, 0, 0, 4,1,0, 4'b0000, 3, 1);
        tbl0[18] = mk(0,1,1,1, 3, 4, 0,0,0, 4'b1101, 3, 1);
        tbl0[19] = mk(0,1,1,1, 3, 4, 0,0,0, 4'b1101, 4, 1);
        tbl0[20] = mk(0,1,1,1, 3, 4, 0,0,0, 4'b0000, 5, 1);
        tbl0[21] = mk(0,1,1,0, 0, 0,12,1,0, 4'b0000, 5, 1);
        tbl0[22] = mk(0,1,1,0,12, 0, 0,0,0, 4'b1101, 5, 1);
        tbl0[23] = mk(1,1,1,0,12, 0, 0,0,0, 4'b0000, 6, 1);
        tbl0[24] = mk(0,1,1,0,12, 0, 0,0,0, 4'b0000, 0, 0);
        // no-bypass build: WB match also stalls
        tbl1[0]  = mk(0,1,1,0, 0, 0, 5,1,0, 4'b0000, 0, 0);
        tbl1[1]  = mk(0,1,1,0, 5, 0, 0,0,0, 4'b1101, 0, 0);
        tbl1[2]  = mk(0,1,1,0, 5, 0, 0,0,0, 4'b1101, 1, 0);
        tbl1[3]  = mk(0,1,1,0, 5, 0, 0,0,0, 4'b1101, 2, 0);
        tbl1[4]  = mk(0,1,1,0, 5, 0, 0,0,0, 4'b0000, 3, 0);
        tbl1[5]  = mk(0,1,1,0, 0, 0, 5,1,0, 4'b0000, 3, 0);
        tbl1[6]  = mk(0,1,1,0, 0, 0, 9,1,0, 4'b0000, 3, 0);
        tbl1[7]  = mk(0,1,0,1, 0, 5, 0,0,0, 4'b1101, 3, 0);
        tbl1[8]  = mk(0,1,0,1, 0, 5, 0,0,0, 4'b1101, 4, 0);
        tbl1[9]  = mk(0,1,0,1, 0, 5, 0,0,0, 4'b0000, 5, 0);

        // common reset of all builds, with a would-be hazard on the inputs
        din0 = tbl0[2].in; din0.rst = 1'b1;
        din1 = tbl0[2].in; din1.rst = 1'b1;
        din2 = tbl0[14].in; din2.rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check($sformatf("reset ctl d%0d", d), {28'd0, get_ctl(d)}, 32'd0);
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) model_reset(d);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset stall_cnt d%0d", d), get_scnt(d), 32'd0);
            check($sformatf("reset flush_cnt d%0d", d), get_fcnt(d), 32'd0);
        end

        for (int i = 0; i < 25; i++) step(0, tbl0[i].in, 1'b1, tbl0[i], $sformatf("tbl0[%0d]", i));
        check("post-reset stall_cnt d0", get_scnt(0), 32'd0);
        check("post-reset flush_cnt d0", get_fcnt(0), 32'd0);
        for (int i = 0; i < 10; i++) step(1, tbl1[i].in, 1'b1, tbl1[i], $sformatf("tbl1[%0d]", i));

        // 4-bit counter wrap: 15 stalls, then one more
        prod5 = tbl0[1].in;
        cons5 = tbl0[2].in;
        cons5.rd = 5'd0;
        for (int i = 0; i < 7; i++) begin
            step(2, prod5, 1'b0, nov, "wrap");
            for (int j = 0; j < 3; j++) step(2, cons5, 1'b0, nov, "wrap");
        end
        step(2, prod5, 1'b0, nov, "wrap");
        step(2, cons5, 1'b0, nov, "wrap");
        check("wrap stall_cnt=15", get_scnt(2), 32'd15);
        step(2, cons5, 1'b0, nov, "wrap");
        check("wrap stall_cnt=0", get_scnt(2), 32'd0);

        // randomized traffic on a small register set to provoke dependencies
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 400; n++) begin
                rv.rst   = ($urandom_range(0, 39) == 0);
                rv.valid = ($urandom_range(0, 3) != 0);
                rv.r1u   = 1'($urandom_range(0, 1));
                rv.r2u   = 1'($urandom_range(0, 1));
                rv.rs1   = 5'($urandom_range(0, 3));
                rv.rs2   = 5'($urandom_range(0, 3));
                rv.rd    = 5'($urandom_range(0, 3));
                rv.rw    = 1'($urandom_range(0, 1));
                rv.br    = ($urandom_range(0, 7) == 0);
                step(d, rv, 1'b0, nov, $sformatf("rand%0d", n));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
